// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared constants and sequencer state encoding for the 2x2 systolic array
package tpu_pkg;

  localparam int ARRAY_N  = 2;
  localparam int FEED_CYC = ARRAY_N + 2;
  localparam int WB_WORDS = 2 * ARRAY_N;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    FEED,
    DRAIN,
    WB,
    DONE
  } state_e;

endpackage

// File: rtl/act_skew.sv
// rtl/act_skew.sv - per-row activation gating and diagonal skew from unified-buffer lanes
// Row 0 passes the buffer lane through under a registered enable; row r goes through an r-stage delay line.
module act_skew
  import tpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N      = ARRAY_N,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  feed_nxt_i,
  input  logic [CNT_W-1:0]      cnt_nxt_i,
  input  logic [N*DATA_W-1:0]   rd_data_i,
  output logic [N*DATA_W-1:0]   a_o
);

  logic [N-1:0] en_d, en_q;

  // Row r carries vector v on feed cycle v+1+r, so its window is cycles r+1 .. r+N.
  always_comb begin
    en_d = '0;
    for (int r = 0; r < N; r++) begin
      en_d[r] = feed_nxt_i && (cnt_nxt_i >= CNT_W'(r + 1)) && (cnt_nxt_i <= CNT_W'(r + N));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q <= '0;
    end else begin
      en_q <= en_d;
    end
  end

  assign a_o[DATA_W-1:0] = rd_data_i[DATA_W-1:0] & {DATA_W{en_q[0]}};

  for (genvar r = 1; r < N; r++) begin : g_row
    logic [DATA_W-1:0] dly_q [r];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < r; k++) dly_q[k] <= '0;
      end else begin
        dly_q[0] <= rd_data_i[r*DATA_W +: DATA_W];
        for (int k = 1; k < r; k++) dly_q[k] <= dly_q[k-1];
      end
    end

    assign a_o[r*DATA_W +: DATA_W] = dly_q[r-1] & {DATA_W{en_q[r]}};
  end

endmodule

// File: rtl/mmu_sequencer.sv
// rtl/mmu_sequencer.sv - control FSM for one 2x2 matrix multiply: load, feed, drain, write-back
// Optional MMU_SEQ_RELU_EN clamps negative accumulator words to zero on write-back.
module mmu_sequencer
  import tpu_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int ADDR_W    = 8,
  parameter int DRAIN_CYC = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   act_base,
  input  logic [ADDR_W-1:0]   out_base,
  output logic                busy,
  output logic                done,
  output logic                load_weight,
  output logic                acc_clear,
  output logic                valid,
  output logic [DATA_W-1:0]   a_in1,
  output logic [DATA_W-1:0]   a_in2,
  output logic                ub_rd_en,
  output logic [ADDR_W-1:0]   ub_rd_addr,
  input  logic [2*DATA_W-1:0] ub_rd_data,
  output logic                acc_rd_sel,
  input  logic [ACC_W-1:0]    acc1_data,
  input  logic [ACC_W-1:0]    acc2_data,
  output logic                ub_wr_en,
  output logic [ADDR_W-1:0]   ub_wr_addr,
  output logic [ACC_W-1:0]    ub_wr_data
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_CYC - 1);
  localparam logic [CNT_W-1:0] WB_LAST    = CNT_W'(WB_WORDS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   act_base_q, act_base_d;
  logic [ADDR_W-1:0]   out_base_q, out_base_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                lw_q, lw_d;
  logic                valid_q, valid_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                sel_q, sel_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                wr_hi_q, wr_hi_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_base_d = act_base_q;
    out_base_d = out_base_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (start) begin
          state_d    = LOAD_W;
          act_base_d = act_base;
          out_base_d = out_base;
        end
      end
      LOAD_W: begin
        state_d = FEED;
        cnt_d   = '0;
      end
      FEED: begin
        if (cnt_q == FEED_LAST) begin
          cnt_d   = '0;
          state_d = (DRAIN_CYC == 0) ? WB : DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = WB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB: begin
        if (cnt_q == WB_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so each registered strobe lines up with its state.
  always_comb begin
    busy_d    = (state_d != IDLE) && (state_d != DONE);
    done_d    = (state_d == DONE);
    lw_d      = (state_d == LOAD_W);
    valid_d   = ((state_d == FEED) && (cnt_d != '0)) || (state_d == DRAIN);
    rd_en_d   = (state_d == FEED) && (cnt_d < CNT_W'(ARRAY_N));
    rd_addr_d = rd_en_d ? act_base_q + ADDR_W'(cnt_d) : '0;
    wr_en_d   = (state_d == WB);
    wr_addr_d = wr_en_d ? out_base_q + ADDR_W'(cnt_d) : '0;
    sel_d     = wr_en_d && cnt_d[0];
    wr_hi_d   = wr_en_d && cnt_d[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      act_base_q <= '0;
      out_base_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lw_q       <= 1'b0;
      valid_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      sel_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_hi_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      act_base_q <= act_base_d;
      out_base_q <= out_base_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      lw_q       <= lw_d;
      valid_q    <= valid_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      sel_q      <= sel_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_hi_q    <= wr_hi_d;
    end
  end

  logic [ARRAY_N*DATA_W-1:0] a_flat;

  act_skew #(
    .DATA_W (DATA_W),
    .N      (ARRAY_N),
    .CNT_W  (CNT_W)
  ) u_act_skew (
    .clk        (clk),
    .reset      (reset),
    .feed_nxt_i (state_d == FEED),
    .cnt_nxt_i  (cnt_d),
    .rd_data_i  (ub_rd_data),
    .a_o        (a_flat)
  );

  // Accumulators are read combinationally, so the write word follows the registered select.
  logic [ACC_W-1:0] acc_word;
  assign acc_word = wr_hi_q ? acc2_data : acc1_data;

`ifdef MMU_SEQ_RELU_EN
  assign ub_wr_data = (wr_en_q && !acc_word[ACC_W-1]) ? acc_word : '0;
`else
  assign ub_wr_data = wr_en_q ? acc_word : '0;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign load_weight = lw_q;
  assign acc_clear   = lw_q;
  assign valid       = valid_q;
  assign a_in1       = a_flat[DATA_W-1:0];
  assign a_in2       = a_flat[2*DATA_W-1:DATA_W];
  assign ub_rd_en    = rd_en_q;
  assign ub_rd_addr  = rd_addr_q;
  assign acc_rd_sel  = sel_q;
  assign ub_wr_en    = wr_en_q;
  assign ub_wr_addr  = wr_addr_q;

endmodule

// File: tb/tb_mmu_sequencer.sv
// tb/tb_mmu_sequencer.sv - scoreboard bench for mmu_sequencer with buffer and accumulator stubs
module tb_mmu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  act_base = '0;
  logic [7:0]  out_base = '0;
  logic        busy, done, load_weight, acc_clear, valid;
  logic [15:0] a_in1, a_in2;
  logic        ub_rd_en;
  logic [7:0]  ub_rd_addr;
  logic [31:0] ub_rd_data = '0;
  logic        acc_rd_sel;
  logic [31:0] acc1_data, acc2_data;
  logic        ub_wr_en;
  logic [7:0]  ub_wr_addr;
  logic [31:0] ub_wr_data;

  always #5 clk = ~clk;

  mmu_sequencer #(
    .DATA_W    (16),
    .ACC_W     (32),
    .ADDR_W    (8),
    .DRAIN_CYC (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .act_base    (act_base),
    .out_base    (out_base),
    .busy        (busy),
    .done        (done),
    .load_weight (load_weight),
    .acc_clear   (acc_clear),
    .valid       (valid),
    .a_in1       (a_in1),
    .a_in2       (a_in2),
    .ub_rd_en    (ub_rd_en),
    .ub_rd_addr  (ub_rd_addr),
    .ub_rd_data  (ub_rd_data),
    .acc_rd_sel  (acc_rd_sel),
    .acc1_data   (acc1_data),
    .acc2_data   (acc2_data),
    .ub_wr_en    (ub_wr_en),
    .ub_wr_addr  (ub_wr_addr),
    .ub_wr_data  (ub_wr_data)
  );

  logic [31:0] mem [256];
  logic [31:0] acc1_m [2];
  logic [31:0] acc2_m [2];

  always @(posedge clk) if (ub_rd_en) ub_rd_data <= mem[ub_rd_addr];
  assign acc1_data = acc1_m[acc_rd_sel];
  assign acc2_data = acc2_m[acc_rd_sel];

`ifdef MMU_SEQ_RELU_EN
  localparam logic [31:0] NEG5_WR = 32'h0000_0000;
`else
  localparam logic [31:0] NEG5_WR = 32'hFFFF_FFFB;
`endif

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         wr_q[$];
  logic [7:0]  rd_q[$];
  logic [31:0] feed_q[$];
  int          lw_q[$];
  int          done_q[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event, value 0x%0h, want none (cycle %0d)", name, act, cyc);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    wr_q.push_back(e);
  endtask

  task automatic push_feed(input logic [15:0] a1, input logic [15:0] a2, input int drain);
    feed_q.push_back({a1, a2});
    for (int i = 0; i < drain; i++) feed_q.push_back(32'h0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_ctrl"}, {56'h0, busy, done, load_weight, acc_clear, valid, ub_rd_en, acc_rd_sel, ub_wr_en}, 64'h0);
    check({name, "_addr"}, {48'h0, ub_rd_addr, ub_wr_addr}, 64'h0);
    check({name, "_ain"},  {32'h0, a_in1, a_in2}, 64'h0);
    check({name, "_wdata"}, {32'h0, ub_wr_data}, 64'h0);
  endtask

  // Monitor: pops the expected response whenever the DUT presents the matching output.
  always @(negedge clk) begin
    if (!reset) begin
      if (ub_rd_en) begin
        if (rd_q.size() == 0) unexpected("rd", {56'h0, ub_rd_addr});
        else check("rd_addr", {56'h0, ub_rd_addr}, {56'h0, rd_q.pop_front()});
      end
      if (valid) begin
        if (feed_q.size() == 0) unexpected("feed", {32'h0, a_in1, a_in2});
        else check("a_in1_a_in2", {32'h0, a_in1, a_in2}, {32'h0, feed_q.pop_front()});
      end else if (busy) begin
        check("a_in_idle_zero", {32'h0, a_in1, a_in2}, 64'h0);
      end
      if (load_weight) begin
        if (lw_q.size() == 0) unexpected("load_weight", 64'(cyc));
        else begin
          check("load_weight_cycle", 64'(cyc), 64'(lw_q.pop_front()));
          check("acc_clear", {63'h0, acc_clear}, 64'h1);
        end
      end
      if (ub_wr_en) begin
        if (wr_q.size() == 0) unexpected("wr", {24'h0, ub_wr_addr, ub_wr_data});
        else begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", {56'h0, ub_wr_addr}, {56'h0, e.a});
          check("wr_data", {32'h0, ub_wr_data}, {32'h0, e.d});
        end
      end
      if (done) begin
        if (done_q.size() == 0) unexpected("done", 64'(cyc));
        else begin
          check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
          check("done_busy", {63'h0, busy}, 64'h0);
        end
      end
    end
  end

  initial begin
    int k;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h20] = 32'h0015_000B;
    mem[8'h21] = 32'h0016_000C;
    mem[8'hFF] = 32'h0005_0003;
    mem[8'h00] = 32'h0007_0004;
    mem[8'h30] = 32'h0002_0001;
    mem[8'h31] = 32'h0004_0003;
    acc1_m[0] = 32'd100; acc1_m[1] = 32'd200;
    acc2_m[0] = 32'd300; acc2_m[1] = 32'd400;

    repeat (3) @(posedge clk);
    #1 check_quiet("in_reset");
    @(negedge clk) reset = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1 check_quiet("idle");
    end

    // Nominal run with write-back and a stray start while busy.
    @(negedge clk);
    act_base = 8'h20; out_base = 8'h10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = cyc;
    lw_q.push_back(k); done_q.push_back(k + 12);
    rd_q.push_back(8'h20); rd_q.push_back(8'h21);
    push_feed(16'd11, 16'd0, 0); push_feed(16'd12, 16'd21, 0); push_feed(16'd0, 16'd22, 3);
    push_wr(8'h10, 32'd100); push_wr(8'h11, 32'd200); push_wr(8'h12, 32'd300); push_wr(8'h13, 32'd400);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (14) @(posedge clk);

    // Address wrap, signed word, and back-to-back run with start held through DONE.
    acc1_m[0] = 32'hFFFF_FFFB; acc1_m[1] = 32'd7;
    acc2_m[0] = 32'd9;         acc2_m[1] = 32'h7FFF_FFFF;
    @(negedge clk);
    act_base = 8'hFF; out_base = 8'hFE; start = 1'b1;
    @(posedge clk);
    #1 k = cyc;
    lw_q.push_back(k); done_q.push_back(k + 12);
    rd_q.push_back(8'hFF); rd_q.push_back(8'h00);
    push_feed(16'd3, 16'd0, 0); push_feed(16'd4, 16'd5, 0); push_feed(16'd0, 16'd7, 3);
    push_wr(8'hFE, NEG5_WR); push_wr(8'hFF, 32'd7); push_wr(8'h00, 32'd9); push_wr(8'h01, 32'h7FFF_FFFF);
    lw_q.push_back(k + 13); done_q.push_back(k + 25);
    rd_q.push_back(8'h30); rd_q.push_back(8'h31);
    push_feed(16'd1, 16'd0, 0); push_feed(16'd3, 16'd2, 0); push_feed(16'd0, 16'd4, 3);
    push_wr(8'h40, NEG5_WR); push_wr(8'h41, 32'd7); push_wr(8'h42, 32'd9); push_wr(8'h43, 32'h7FFF_FFFF);
    @(negedge clk);
    act_base = 8'h30; out_base = 8'h40;
    repeat (13) @(posedge clk);
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (14) @(posedge clk);

    // Reset asserted during write-back word 1.
    acc1_m[0] = 32'd100; acc1_m[1] = 32'd200;
    acc2_m[0] = 32'd300; acc2_m[1] = 32'd400;
    @(negedge clk);
    act_base = 8'h20; out_base = 8'h10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = cyc;
    lw_q.push_back(k);
    rd_q.push_back(8'h20); rd_q.push_back(8'h21);
    push_feed(16'd11, 16'd0, 0); push_feed(16'd12, 16'd21, 0); push_feed(16'd0, 16'd22, 3);
    push_wr(8'h10, 32'd100);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1 check_quiet("reset_mid_wb");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (6) @(posedge clk);
    #1 check_quiet("after_abort");

    check("rd_q_left",   64'(rd_q.size()),   64'h0);
    check("feed_q_left", 64'(feed_q.size()), 64'h0);
    check("wr_q_left",   64'(wr_q.size()),   64'h0);
    check("lw_q_left",   64'(lw_q.size()),   64'h0);
    check("done_q_left", 64'(done_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
